// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two issuing requesters, the arbiter and the response consumer.
// Latency: pure wiring, no storage.
// Backpressure: reqX_ready gates each request; resp_ready holds the response in place.
interface alu_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_rs1;
    logic [DATA_W-1:0] req0_rs2;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_rs1;
    logic [DATA_W-1:0] req1_rs2;
    logic [OP_W-1:0]   req1_op;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_out;
    logic              resp_carry;
    logic              resp_err;

    // Requester/consumer side: drives requests, accepts responses.
    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_op,
        output req1_valid, req1_rs1, req1_rs2, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_out, resp_carry, resp_err
    );

    // Arbiter side: accepts requests, produces responses.
    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_op,
        input  req1_valid, req1_rs1, req1_rs2, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_out, resp_carry, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational 8-bit ALU between two requesters, with error flagging.
// Latency: accept in IDLE, one EXEC cycle, response valid two cycles after the accept edge.
// Backpressure: response held until resp_ready; no new grant while an operation is in flight.
module alu_arbiter #(
    parameter int               DATA_W      = 8,
    parameter int               OP_W        = 4,
    parameter logic [DATA_W-1:0] DIV0_RESULT = 8'hFF,
    parameter int               CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_rs1_o,
    output logic [DATA_W-1:0] alu_rs2_o,
    output logic [OP_W-1:0]   alu_opcode_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_carry_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  op_count_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    localparam logic [OP_W-1:0] OP_DIV    = 4'b1001;
    localparam logic [OP_W-1:0] OP_ILL_LO = 4'b1010;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] alu_rs1_q, alu_rs1_d;
    logic [DATA_W-1:0] alu_rs2_q, alu_rs2_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_out_q, resp_out_d;
    logic              resp_carry_q, resp_carry_d;
    logic              resp_err_q, resp_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              grant0, grant1;

    // Next-state, grant and datapath capture; every register holds unless its state acts on it.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        alu_rs1_d    = alu_rs1_q;
        alu_rs2_d    = alu_rs2_q;
        alu_op_d     = alu_op_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_carry_d = resp_carry_q;
        resp_err_d   = resp_err_q;
        op_count_d   = op_count_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rr_ptr only breaks ties; a lone valid requester always wins.
                grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
                grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
                if (grant0) begin
                    alu_rs1_d = bus.req0_rs1;
                    alu_rs2_d = bus.req0_rs2;
                    alu_op_d  = bus.req0_op;
                    resp_id_d = 1'b0;
                    state_d   = ST_EXEC;
                end else if (grant1) begin
                    alu_rs1_d = bus.req1_rs1;
                    alu_rs2_d = bus.req1_rs2;
                    alu_op_d  = bus.req1_op;
                    resp_id_d = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Error cases override whatever the ALU produced for those opcodes.
                if (alu_op_q == OP_DIV && alu_rs2_q == '0) begin
                    resp_out_d   = DIV0_RESULT;
                    resp_carry_d = 1'b0;
                    resp_err_d   = 1'b1;
                end else if (alu_op_q >= OP_ILL_LO) begin
                    resp_out_d   = '0;
                    resp_carry_d = 1'b0;
                    resp_err_d   = 1'b1;
                end else begin
                    resp_out_d   = alu_out_i;
                    resp_carry_d = alu_carry_i;
                    resp_err_d   = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    rr_ptr_d = ~resp_id_q;
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            alu_rs1_q    <= '0;
            alu_rs2_q    <= '0;
            alu_op_q     <= '0;
            resp_id_q    <= 1'b0;
            resp_out_q   <= '0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_rs1_q    <= alu_rs1_d;
            alu_rs2_q    <= alu_rs2_d;
            alu_op_q     <= alu_op_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_carry_q <= resp_carry_d;
            resp_err_q   <= resp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.resp_carry = resp_carry_q;
    assign bus.resp_err   = resp_err_q;
    assign alu_rs1_o      = alu_rs1_q;
    assign alu_rs2_o      = alu_rs2_q;
    assign alu_opcode_o   = alu_op_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign op_count_o     = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, backpressure, errors, reset mid-op, saturation.
// Latency: checks responses two cycles after each accept.
// Backpressure: exercises resp_ready held low for several cycles.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(8), .OP_W(4)) bus ();
    alu_arbiter_if #(.DATA_W(8), .OP_W(4)) bus2 ();

    logic [7:0]  alu_rs1, alu_rs2, alu_out;
    logic [3:0]  alu_op;
    logic        alu_carry, busy;
    logic [15:0] op_count;

    logic [7:0]  alu_rs1_2, alu_rs2_2, alu_out_2;
    logic [3:0]  alu_op_2;
    logic        alu_carry_2, busy_2;
    logic [1:0]  op_count_2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, 9 DIV; else 0.
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        case (op)
            4'h0: r = {1'b0, a} + {1'b0, b};
            4'h1: r = {1'b0, a} - {1'b0, b};
            4'h2: r = {1'b0, a & b};
            4'h3: r = {1'b0, a | b};
            4'h4: r = {1'b0, a ^ b};
            4'h9: r = (b == 8'h00) ? 9'h000 : {1'b0, a / b};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign {alu_carry,   alu_out}   = alu_model(alu_op,   alu_rs1,   alu_rs2);
    assign {alu_carry_2, alu_out_2} = alu_model(alu_op_2, alu_rs1_2, alu_rs2_2);

    alu_arbiter #(.DATA_W(8), .OP_W(4), .DIV0_RESULT(8'hFF), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2), .alu_opcode_o(alu_op),
        .alu_out_i(alu_out), .alu_carry_i(alu_carry),
        .busy_o(busy), .op_count_o(op_count)
    );

    alu_arbiter #(.DATA_W(8), .OP_W(4), .DIV0_RESULT(8'hFF), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2),
        .alu_rs1_o(alu_rs1_2), .alu_rs2_o(alu_rs2_2), .alu_opcode_o(alu_op_2),
        .alu_out_i(alu_out_2), .alu_carry_i(alu_carry_2),
        .busy_o(busy_2), .op_count_o(op_count_2)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (op_count !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0", op_count); end
        n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err} !== 12'h000) begin
            n_bad++; $display("FAIL reset_resp: got %h want 000", {bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err}); end
        n_cmp++; if ({alu_rs1, alu_rs2, alu_op} !== 20'h0) begin n_bad++; $display("FAIL reset_alu: got %h want 0", {alu_rs1, alu_rs2, alu_op}); end
        n_cmp++; if (op_count_2 !== 2'b00) begin n_bad++; $display("FAIL reset_count_sat: got %b want 00", op_count_2); end
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL reset_priority: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_single();
        cyc();
        bus.resp_ready = 1'b1;
        bus.req0_rs1 = 8'hF0; bus.req0_rs2 = 8'h20; bus.req0_op = 4'h0;
        bus.req0_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL single_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        cyc();
        bus.req0_valid = 1'b0;
        n_cmp++; if ({busy, bus.resp_valid} !== 2'b10) begin n_bad++; $display("FAIL single_exec: busy,valid got %b want 10", {busy, bus.resp_valid}); end
        n_cmp++; if ({alu_rs1, alu_rs2, alu_op} !== {8'hF0, 8'h20, 4'h0}) begin
            n_bad++; $display("FAIL single_alu_regs: got %h want f0200", {alu_rs1, alu_rs2, alu_op}); end
        cyc();
        n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL single_resp: {v,id,out,c,err} got %h want %h",
                {bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err}, {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}); end
        cyc();
        n_cmp++; if ({bus.resp_valid, busy, op_count} !== {2'b00, 16'd1}) begin
            n_bad++; $display("FAIL single_done: {v,busy,count} got %h want %h", {bus.resp_valid, busy, op_count}, {2'b00, 16'd1}); end
    endtask

    task automatic test_contention();
        logic exp_id;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        bus.req0_rs1 = 8'h03; bus.req0_rs2 = 8'h04; bus.req0_op = 4'h0;
        bus.req1_rs1 = 8'hAA; bus.req1_rs2 = 8'h0F; bus.req1_op = 4'h4;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2) == 1;
            #1;
            n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL contention_grant[%0d]: got %b want %b", i, {bus.req0_ready, bus.req1_ready}, exp_id ? 2'b01 : 2'b10); end
            cyc();
            cyc();
            n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_out} !== {1'b1, exp_id, (exp_id ? 8'hA5 : 8'h07)}) begin
                n_bad++; $display("FAIL contention_resp[%0d]: {v,id,out} got %h want %h", i,
                    {bus.resp_valid, bus.resp_id, bus.resp_out}, {1'b1, exp_id, (exp_id ? 8'hA5 : 8'h07)}); end
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_cmp++; if (op_count !== 16'd4) begin n_bad++; $display("FAIL contention_count: got %0d want 4", op_count); end
    endtask

    task automatic test_back_to_back_backpressure();
        bus.resp_ready = 1'b0;
        bus.req1_rs1 = 8'h05; bus.req1_rs2 = 8'h07; bus.req1_op = 4'h1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        cyc();
        bus.req1_valid = 1'b0;
        cyc();
        bus.req0_rs1 = 8'h11; bus.req0_rs2 = 8'h22; bus.req0_op = 4'h0;
        bus.req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err} !== {1'b1, 1'b1, 8'hFE, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL bp_hold[%0d]: {v,id,out,c,err} got %h want %h", k,
                    {bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err}, {1'b1, 1'b1, 8'hFE, 1'b1, 1'b0}); end
            n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_grant[%0d]: got %b want 0", k, bus.req0_ready); end
            cyc();
        end
        bus.resp_ready = 1'b1;
        cyc();
        #1;
        n_cmp++; if ({bus.resp_valid, op_count, bus.req0_ready} !== {1'b0, 16'd5, 1'b1}) begin
            n_bad++; $display("FAIL bp_release: {v,count,rdy0} got %h want %h", {bus.resp_valid, op_count, bus.req0_ready}, {1'b0, 16'd5, 1'b1}); end
        bus.req0_valid = 1'b0;
    endtask

    task automatic test_errors();
        logic [3:0] ops   [3] = '{4'h9, 4'hC, 4'h9};
        logic [7:0] a_v   [3] = '{8'h10, 8'h12, 8'h10};
        logic [7:0] b_v   [3] = '{8'h00, 8'h34, 8'h04};
        logic [7:0] e_out [3] = '{8'hFF, 8'h00, 8'h04};
        logic       e_err [3] = '{1'b1, 1'b1, 1'b0};
        cyc();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0_rs1 = a_v[i]; bus.req0_rs2 = b_v[i]; bus.req0_op = ops[i];
            bus.req0_valid = 1'b1;
            cyc();
            bus.req0_valid = 1'b0;
            cyc();
            n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err} !== {1'b1, 1'b0, e_out[i], 1'b0, e_err[i]}) begin
                n_bad++; $display("FAIL errors[%0d]: {v,id,out,c,err} got %h want %h", i,
                    {bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_carry, bus.resp_err}, {1'b1, 1'b0, e_out[i], 1'b0, e_err[i]}); end
            cyc();
        end
        n_cmp++; if (op_count !== 16'd8) begin n_bad++; $display("FAIL errors_count: got %0d want 8", op_count); end
    endtask

    task automatic test_reset_mid_op();
        bus.req1_rs1 = 8'h01; bus.req1_rs2 = 8'h01; bus.req1_op = 4'h0;
        bus.req1_valid = 1'b1;
        cyc();
        bus.req1_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_inflight: busy got %b want 1", busy); end
        rst = 1'b1;
        cyc();
        n_cmp++; if ({bus.resp_valid, busy, op_count} !== {2'b00, 16'd0}) begin
            n_bad++; $display("FAIL midrst_cleared: {v,busy,count} got %h want 0", {bus.resp_valid, busy, op_count}); end
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL midrst_priority: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if ({bus.resp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_no_resp: {v,busy} got %b want 00", {bus.resp_valid, busy}); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        bus2.resp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus2.req0_rs1 = 8'(k); bus2.req0_rs2 = 8'(k); bus2.req0_op = 4'h0;
            bus2.req0_valid = 1'b1;
            cyc();
            bus2.req0_valid = 1'b0;
            cyc();
            n_cmp++; if (bus2.resp_out !== 8'(2 * k)) begin
                n_bad++; $display("FAIL sat_out[%0d]: got %h want %h", k, bus2.resp_out, 8'(2 * k)); end
            cyc();
            exp_cnt = (k >= 3) ? 2'b11 : 2'(k);
            n_cmp++; if (op_count_2 !== exp_cnt) begin
                n_bad++; $display("FAIL sat_count[%0d]: got %b want %b", k, op_count_2, exp_cnt); end
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_rs1 = 8'h00; bus.req0_rs2 = 8'h00; bus.req0_op = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_rs1 = 8'h00; bus.req1_rs2 = 8'h00; bus.req1_op = 4'h0;
        bus.resp_ready = 1'b0;
        bus2.req0_valid = 1'b0; bus2.req0_rs1 = 8'h00; bus2.req0_rs2 = 8'h00; bus2.req0_op = 4'h0;
        bus2.req1_valid = 1'b0; bus2.req1_rs1 = 8'h00; bus2.req1_rs2 = 8'h00; bus2.req1_op = 4'h0;
        bus2.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back_backpressure();
        test_errors();
        test_reset_mid_op();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
